gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank.sv | 189 ++++++++++++++++++
 tb/tb_gpio_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// GPIO bank: PORTS ports of WIDTH pins, each with OUT/DIR/SET/CLR/TGL
// registers, a synchronized IN view, per-pin rise/fall event flags with
// write-one-to-clear, per-flag interrupt enables and a registered irq.
//
// Bus protocol: io_wr and io_rd are single-cycle strobes with no
// backpressure. An access completes on the clock edge where its strobe is
// sampled high, and read data is valid from the following cycle.
module gpio_bank #(
    parameter int PORTS = 3,
    parameter int WIDTH = 8,
    parameter int SYNC  = 2
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic                   io_wr,
    input  logic                   io_rd,
    input  logic [5:0]             addr,
    input  logic [15:0]            wdata,
    output logic [15:0]            rdata,
    input  logic [PORTS*WIDTH-1:0] pin_in,
    output logic [PORTS*WIDTH-1:0] pin_out,
    output logic [PORTS*WIDTH-1:0] pin_oe,
    output logic                   irq
);

    localparam int N = PORTS * WIDTH;

    localparam logic [2:0] REG_IN  = 3'd0;
    localparam logic [2:0] REG_OUT = 3'd1;
    localparam logic [2:0] REG_DIR = 3'd2;
    localparam logic [2:0] REG_SET = 3'd3;
    localparam logic [2:0] REG_CLR = 3'd4;
    localparam logic [2:0] REG_TGL = 3'd5;
    localparam logic [2:0] REG_EVT = 3'd6;
    localparam logic [2:0] REG_IEN = 3'd7;

    logic [WIDTH-1:0] out_q      [PORTS];
    logic [WIDTH-1:0] dir_q      [PORTS];
    logic [WIDTH-1:0] evt_rise_q [PORTS];
    logic [WIDTH-1:0] evt_fall_q [PORTS];
    logic [WIDTH-1:0] ien_rise_q [PORTS];
    logic [WIDTH-1:0] ien_fall_q [PORTS];
    logic [WIDTH-1:0] clr_rise_w [PORTS];
    logic [WIDTH-1:0] clr_fall_w [PORTS];

    logic [N-1:0]     sync_q [SYNC];
    logic [N-1:0]     prev_q;
    logic [N-1:0]     in_w;
    logic [N-1:0]     rise_w;
    logic [N-1:0]     fall_w;

    logic [PORTS-1:0] port_sel;
    logic [2:0]       reg_sel;
    logic [WIDTH-1:0] wlo;
    logic [WIDTH-1:0] whi;
    logic [15:0]      rd_val;
    logic             irq_w;

    // Place a WIDTH-bit value in the low byte of a zeroed 16-bit word.
    function automatic logic [15:0] pack_lo(input logic [WIDTH-1:0] v);
        logic [15:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Place rise bits in the low byte and fall bits in the high byte.
    function automatic logic [15:0] pack_hl(input logic [WIDTH-1:0] lo,
                                            input logic [WIDTH-1:0] hi);
        logic [15:0] r;
        r = '0;
        r[WIDTH-1:0]   = lo;
        r[8+WIDTH-1:8] = hi;
        return r;
    endfunction

    assign reg_sel = addr[2:0];
    assign wlo     = wdata[WIDTH-1:0];
    assign whi     = wdata[8 +: WIDTH];
    assign in_w    = sync_q[SYNC-1];
    assign rise_w  = in_w & ~prev_q;
    assign fall_w  = ~in_w & prev_q;

    // Port decode and EVT write-one-to-clear masks; out-of-range ports never match.
    always_comb begin
        port_sel = '0;
        for (int p = 0; p < PORTS; p++) begin
            port_sel[p] = (addr[5:3] == p[2:0]);
            clr_rise_w[p] = '0;
            clr_fall_w[p] = '0;
            if (io_wr && (addr[5:3] == p[2:0]) && (reg_sel == REG_EVT)) begin
                clr_rise_w[p] = wlo;
                clr_fall_w[p] = whi;
            end
        end
    end

    // Pads follow the OUT and DIR registers directly.
    always_comb begin
        pin_out = '0;
        pin_oe  = '0;
        for (int p = 0; p < PORTS; p++) begin
            pin_out[p*WIDTH +: WIDTH] = out_q[p];
            pin_oe[p*WIDTH +: WIDTH]  = dir_q[p];
        end
    end

    // Input synchronizer chain plus the one-cycle-delayed copy used for edges.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= in_w;
        end
    end

    // Per-port registers; an edge seen in the same cycle as its W1C keeps the flag set.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int p = 0; p < PORTS; p++) begin
                out_q[p]      <= '0;
                dir_q[p]      <= '0;
                evt_rise_q[p] <= '0;
                evt_fall_q[p] <= '0;
                ien_rise_q[p] <= '0;
                ien_fall_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (io_wr && port_sel[p]) begin
                    case (reg_sel)
                        REG_OUT: out_q[p] <= wlo;
                        REG_DIR: dir_q[p] <= wlo;
                        REG_SET: out_q[p] <= out_q[p] | wlo;
                        REG_CLR: out_q[p] <= out_q[p] & ~wlo;
                        REG_TGL: out_q[p] <= out_q[p] ^ wlo;
                        REG_IEN: begin
                            ien_rise_q[p] <= wlo;
                            ien_fall_q[p] <= whi;
                        end
                        default: ;
                    endcase
                end
                evt_rise_q[p] <= (evt_rise_q[p] & ~clr_rise_w[p]) | rise_w[p*WIDTH +: WIDTH];
                evt_fall_q[p] <= (evt_fall_q[p] & ~clr_fall_w[p]) | fall_w[p*WIDTH +: WIDTH];
            end
        end
    end

    // Read mux over current register contents (pre-write on a same-cycle write).
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (port_sel[p]) begin
                case (reg_sel)
                    REG_IN:  rd_val = pack_lo(in_w[p*WIDTH +: WIDTH]);
                    REG_DIR: rd_val = pack_lo(dir_q[p]);
                    REG_EVT: rd_val = pack_hl(evt_rise_q[p], evt_fall_q[p]);
                    REG_IEN: rd_val = pack_hl(ien_rise_q[p], ien_fall_q[p]);
                    default: rd_val = pack_lo(out_q[p]);
                endcase
            end
        end
    end

    // Interrupt source: any enabled pending flag on any port.
    always_comb begin
        irq_w = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            irq_w = irq_w | (|((evt_rise_q[p] & ien_rise_q[p]) |
                               (evt_fall_q[p] & ien_fall_q[p])));
        end
    end

    // Registered read data (held between reads) and registered irq.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            if (io_rd) rdata <= rd_val;
            irq <= irq_w;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with default parameters (3 ports x 8 pins, SYNC=2).
module tb_gpio_bank;

    logic        clk;
    logic        resetq;
    logic        io_wr;
    logic        io_rd;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [23:0] pin_in;
    logic [23:0] pin_out;
    logic [23:0] pin_oe;
    logic        irq;

    int checks;
    int errors;

    gpio_bank #(.PORTS(3), .WIDTH(8), .SYNC(2)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .io_wr   (io_wr),
        .io_rd   (io_rd),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and count.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle write strobe; effect is visible on return.
    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        io_wr = 1'b1;
        addr  = a;
        wdata = d;
        step(1);
        io_wr = 1'b0;
    endtask

    // One-cycle read strobe; rdata is valid on return.
    task automatic rd(input logic [5:0] a);
        io_rd = 1'b1;
        addr  = a;
        step(1);
        io_rd = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetq = 1'b0;
        io_wr  = 1'b0;
        io_rd  = 1'b0;
        addr   = '0;
        wdata  = '0;
        pin_in = '0;
        step(3);

        // Reset state
        chk("rst_pin_out", pin_out, 0);
        chk("rst_pin_oe",  pin_oe,  0);
        chk("rst_irq",     irq,     0);
        chk("rst_rdata",   rdata,   0);
        resetq = 1'b1;
        step(2);

        // Port 1 OUT/DIR and SET/CLR/TGL: 0F|30=3F, &~01=3E, ^81=BF
        wr(6'd10, 16'h00FF);
        wr(6'd9,  16'h000F);
        wr(6'd11, 16'h0030);
        wr(6'd12, 16'h0001);
        wr(6'd13, 16'h0081);
        chk("p1_pin_out", pin_out, 24'h00BF00);
        chk("p1_pin_oe",  pin_oe,  24'h00FF00);
        rd(6'd9);
        chk("p1_rd_out", rdata, 16'h00BF);
        rd(6'd11);
        chk("p1_rd_set", rdata, 16'h00BF);
        rd(6'd10);
        chk("p1_rd_dir", rdata, 16'h00FF);
        step(3);
        chk("rdata_hold", rdata, 16'h00FF);

        // Rise on pin 2 with IEN rise bit 2: flag 3 cycles after the pad, irq one later
        wr(6'd7, 16'h0004);
        pin_in = 24'h000004;
        step(2);
        rd(6'd6);
        chk("evt_not_yet", rdata, 16'h0000);
        chk("irq_not_yet", irq, 0);
        rd(6'd6);
        chk("evt_rise2", rdata, 16'h0004);
        chk("irq_set", irq, 1);
        wr(6'd6, 16'h0004);
        chk("irq_lag", irq, 1);
        step(1);
        chk("irq_clr", irq, 0);
        rd(6'd6);
        chk("evt_cleared", rdata, 16'h0000);

        // Fall on pin 3 coinciding with its W1C: event wins
        pin_in = 24'h00000C;
        step(4);
        wr(6'd6, 16'hFFFF);
        rd(6'd6);
        chk("evt_all_clr", rdata, 16'h0000);
        pin_in = 24'h000004;
        step(2);
        wr(6'd6, 16'h0800);
        rd(6'd6);
        chk("evt_wins", rdata, 16'h0800);
        chk("irq_fall_masked", irq, 0);
        wr(6'd6, 16'h0800);
        rd(6'd6);
        chk("evt_w1c", rdata, 16'h0000);

        // IN register and ignored writes to it
        rd(6'd0);
        chk("in_port0", rdata, 16'h0004);
        wr(6'd0, 16'h00FF);
        rd(6'd0);
        chk("in_wr_ignored", rdata, 16'h0004);

        // Out-of-range ports: writes ignored, reads zero
        wr(6'd41, 16'hFFFF);
        wr(6'd42, 16'hFFFF);
        wr(6'd25, 16'hFFFF);
        chk("oor_pin_out", pin_out, 24'h00BF00);
        chk("oor_pin_oe",  pin_oe,  24'h00FF00);
        rd(6'd9);
        chk("oor_pre_rd", rdata, 16'h00BF);
        rd(6'd41);
        chk("oor_rd5", rdata, 16'h0000);
        rd(6'd9);
        rd(6'd25);
        chk("oor_rd3", rdata, 16'h0000);

        // Same-cycle read and write returns the pre-write value
        io_rd = 1'b1;
        io_wr = 1'b1;
        addr  = 6'd9;
        wdata = 16'h0055;
        step(1);
        io_rd = 1'b0;
        io_wr = 1'b0;
        chk("rw_pre_value", rdata, 16'h00BF);
        chk("rw_pin_out", pin_out, 24'h005500);

        // Upper write bits ignored
        wr(6'd9, 16'hFF3C);
        rd(6'd9);
        chk("upper_bits", rdata, 16'h003C);

        // Fall on pin 2 with IEN fall bit 2, then async reset mid-operation
        wr(6'd7, 16'h0404);
        pin_in = 24'h000000;
        step(5);
        chk("irq_fall", irq, 1);
        rd(6'd6);
        chk("evt_fall2", rdata, 16'h0400);
        wr(6'd9, 16'h00FF);
        rd(6'd9);
        chk("pre_rst_out", rdata, 16'h00FF);
        chk("pre_rst_pins", pin_out, 24'h00FF00);
        #2;
        resetq = 1'b0;
        #1;
        chk("arst_pin_out", pin_out, 0);
        chk("arst_pin_oe",  pin_oe,  0);
        chk("arst_irq",     irq,     0);
        chk("arst_rdata",   rdata,   0);
        step(2);
        resetq = 1'b1;
        step(2);
        rd(6'd6);
        chk("post_rst_evt", rdata, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
